uriscv_dmem: RTL

URISCV_DMEM -- requirements
Module: uriscv_dmem

---
 rtl/uriscv_pkg.sv | 29 ++
 rtl/uriscv_dmem_ram.sv | 41 ++++
 rtl/uriscv_dmem.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uriscv_pkg.sv
// ----------------------------------------------------------------------------
// uriscv_pkg
//   Shared definitions for the uriscv data-memory slice.
//   - state_e        : access sequencer states (IDLE / WAIT / RESP)
//   - DMEM_BASE_ADDR : default byte address of data-memory word 0
//   - dmem_in_range  : helper that tests a byte address against a window
// ----------------------------------------------------------------------------
package uriscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h0001_0000;

    // Window check done in 33 bits so a window that ends at 4 GiB cannot wrap.
    function automatic logic dmem_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] limit
    );
        logic [32:0] a33;
        a33 = {1'b0, addr};
        return (a33 >= {1'b0, base}) && (a33 < limit);
    endfunction

endpackage

// File: rtl/uriscv_dmem_ram.sv
// ----------------------------------------------------------------------------
// uriscv_dmem_ram
//   Single-port word RAM with four byte-lane write enables, synchronous
//   read and write, no reset (contents survive reset).
//
//   Ports:
//     i_clk    - clock
//     i_en     - access enable for this cycle
//     i_we     - byte-lane write enables; all zero with i_en means read
//     i_addr   - word index
//     i_wdata  - lane-positioned write data
//     o_rdata  - registered read data; updated only by reads
// ----------------------------------------------------------------------------
module uriscv_dmem_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            if (i_we == '0) begin
                o_rdata <= r_mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/uriscv_dmem.sv
// ----------------------------------------------------------------------------
// uriscv_dmem
//   Wait-stated data memory for the uriscv core. One outstanding access:
//   a request is captured in IDLE, optionally waits WAIT_CYCLES cycles,
//   and completes with a one-cycle ack in RESP. Out-of-window, misaligned
//   or read+write requests complete with error and no write.
//
//   Ports:
//     clk_i            - clock, rising edge
//     rst_i            - synchronous active-high reset
//     mem_rd_i         - read request (held until ack)
//     mem_wr_i[3:0]    - byte-lane write enables (held until ack)
//     mem_addr_i[31:0] - byte address
//     mem_data_i[31:0] - lane-positioned write data
//     mem_misaligned_i - initiator-flagged misaligned access
//     mem_accept_o     - request captured this cycle (combinational)
//     mem_ack_o        - one-cycle completion pulse
//     mem_data_o[31:0] - aligned word read; valid with ack, held otherwise
//     mem_error_o      - access faulted; valid with ack, low otherwise
// ----------------------------------------------------------------------------
module uriscv_dmem
    import uriscv_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_rd_i,
    input  logic [3:0]  mem_wr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_misaligned_i,
    output logic        mem_accept_o,
    output logic        mem_ack_o,
    output logic [31:0] mem_data_o,
    output logic        mem_error_o
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_END  = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wr;
    logic        r_rd;
    logic        r_mis;
    logic        r_ack;
    logic        r_err;
    logic        r_zero;

    logic          w_req;
    logic          w_idle;
    logic          w_accept;
    logic          w_go_resp;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_wr;
    logic          w_rd;
    logic          w_mis;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic          w_ram_en;
    logic [31:0]   w_ram_q;

    assign w_req    = mem_rd_i | (|mem_wr_i);
    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle && w_req && !rst_i;

    // With WAIT_CYCLES=0 the RAM access happens on the capture edge itself,
    // so the access fields come straight from the inputs while in IDLE and
    // from the captured copies otherwise.
    assign w_addr  = w_idle ? mem_addr_i       : r_addr;
    assign w_wdata = w_idle ? mem_data_i       : r_wdata;
    assign w_wr    = w_idle ? mem_wr_i         : r_wr;
    assign w_rd    = w_idle ? mem_rd_i         : r_rd;
    assign w_mis   = w_idle ? mem_misaligned_i : r_mis;

    assign w_err = !dmem_in_range(w_addr, BASE_ADDR, ADDR_END)
                 || w_mis
                 || (w_rd && (|w_wr));

    assign w_idx = AW'((w_addr - BASE_ADDR) >> 2);

    // Asserted in the cycle whose closing edge enters RESP.
    always_comb begin
        w_go_resp = 1'b0;
        if (!rst_i) begin
            if (WAIT_CYCLES == 0) begin
                w_go_resp = w_accept;
            end else begin
                w_go_resp = (r_state == WAIT) && (r_cnt <= 4'd1);
            end
        end
    end

    assign w_ram_en = w_go_resp && !w_err;

    uriscv_dmem_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .i_clk   (clk_i),
        .i_en    (w_ram_en),
        .i_we    (w_wr),
        .i_addr  (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= '0;
            r_rd    <= 1'b0;
            r_mis   <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            r_ack <= w_go_resp;
            r_err <= w_go_resp && w_err;

            // The RAM read register is not reset and only moves on reads;
            // r_zero masks it to zero after reset and after a faulted access.
            if (w_go_resp) begin
                if (w_err) begin
                    r_zero <= 1'b1;
                end else if (w_rd) begin
                    r_zero <= 1'b0;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr  <= mem_addr_i;
                        r_wdata <= mem_data_i;
                        r_wr    <= mem_wr_i;
                        r_rd    <= mem_rd_i;
                        r_mis   <= mem_misaligned_i;
                        r_cnt   <= WAIT_INIT;
                        r_state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_accept_o = w_accept;
    assign mem_ack_o    = r_ack;
    assign mem_error_o  = r_err;
    assign mem_data_o   = r_zero ? '0 : w_ram_q;

endmodule
